// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
// blink_pkg : shared types and defaults for the blink pattern sequencer
// Revision  : 1.0
// ============================================================================
package blink_pkg;

  localparam int MS_DIV_DEFAULT  = 100000;
  localparam int SPEED_W_DEFAULT = 16;
  localparam int DUR_W_DEFAULT   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SPEED_W_DEFAULT-1:0] speed;
    logic [DUR_W_DEFAULT-1:0]   dur;
  } step_t;

endpackage
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
// ms_tick_gen : modulo-TICK_DIV counter producing the shared millisecond tic
// Revision    : 1.0
// ============================================================================
module ms_tick_gen
  import blink_pkg::*;
#(
  parameter int TICK_DIV = MS_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tic
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == C_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The tic lands on the last count so a step of dur ticks spans dur*TICK_DIV cycles.
  assign tic = ~clr & (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
// blink_sequencer : plays a programmable table of {speed, duration} steps
// Revision        : 1.0
// ============================================================================
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SPEED_W  = 16,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = MS_DIV_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [SPEED_W-1:0]       cfg_speed,
  input  logic [DUR_W-1:0]         cfg_dur,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic [SPEED_W-1:0]       speed_out,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] C_LAST_IDX = AW'(DEPTH - 1);

  logic [SPEED_W-1:0] speed_tbl [DEPTH];
  logic [DUR_W-1:0]   dur_tbl   [DEPTH];

  state_t             state_q;
  logic [SPEED_W-1:0] speed_q;
  logic [AW-1:0]      idx_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [DUR_W-1:0]   rem_q;

  logic               w_tic;
  logic               w_clr;
  logic [AW-1:0]      w_next_idx;
  logic               w_pat_end;
  logic [AW-1:0]      w_load_idx;

  assign w_clr = (state_q != RUN);

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tic   (w_tic)
  );

  always_comb begin
    w_next_idx = idx_q + 1'b1;
    w_pat_end  = (idx_q == C_LAST_IDX) || (dur_tbl[w_next_idx] == '0);
    w_load_idx = w_pat_end ? '0 : w_next_idx;
  end

  // Table is deliberately left unreset; writes are accepted only while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == IDLE)) begin
      speed_tbl[cfg_addr] <= cfg_speed;
      dur_tbl[cfg_addr]   <= cfg_dur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      speed_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= cfg_we && (state_q == RUN);
      if (stop) begin
        state_q <= IDLE;
        speed_q <= '0;
        idx_q   <= '0;
        busy_q  <= 1'b0;
        rem_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              idx_q <= '0;
              if (dur_tbl[0] == '0) begin
                state_q <= FIN;
                done_q  <= 1'b1;
                speed_q <= '0;
                busy_q  <= 1'b0;
              end else begin
                state_q <= RUN;
                speed_q <= speed_tbl[0];
                rem_q   <= dur_tbl[0];
                busy_q  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (w_tic) begin
              if (rem_q == DUR_W'(1)) begin
                if (w_pat_end && !loop_en) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
                  speed_q <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  rem_q   <= '0;
                end else begin
                  speed_q <= speed_tbl[w_load_idx];
                  rem_q   <= dur_tbl[w_load_idx];
                  idx_q   <= w_load_idx;
                end
              end else begin
                rem_q <= rem_q - 1'b1;
              end
            end
          end
          FIN: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign speed_out = speed_q;
  assign step_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
// tb_blink_sequencer : directed, table-driven bench for blink_sequencer
// Revision           : 1.0
// ============================================================================
module tb_blink_sequencer;

  localparam int DEPTH    = 4;
  localparam int SPEED_W  = 16;
  localparam int DUR_W    = 16;
  localparam int TICK_DIV = 4;
  localparam int AW       = 2;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               cfg_we    = 1'b0;
  logic [AW-1:0]      cfg_addr  = '0;
  logic [SPEED_W-1:0] cfg_speed = '0;
  logic [DUR_W-1:0]   cfg_dur   = '0;
  logic               start     = 1'b0;
  logic               stop      = 1'b0;
  logic               loop_en   = 1'b0;
  logic [SPEED_W-1:0] speed_out;
  logic [AW-1:0]      step_idx;
  logic               busy;
  logic               done;
  logic               cfg_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic start;
    logic stop;
    logic loop_en;
    int   n;
    int   speed;
    int   idx;
    int   busy;
    int   done;
  } vec_t;

  vec_t vq[$];

  blink_sequencer #(
    .DEPTH    (DEPTH),
    .SPEED_W  (SPEED_W),
    .DUR_W    (DUR_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_speed (cfg_speed),
    .cfg_dur   (cfg_dur),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .speed_out (speed_out),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chk_outs(input string tag, input int sp, input int ix,
                          input int b, input int d, input int e);
    chk({tag, " speed_out"}, int'(speed_out), sp);
    chk({tag, " step_idx"},  int'(step_idx),  ix);
    chk({tag, " busy"},      int'(busy),      b);
    chk({tag, " done"},      int'(done),      d);
    chk({tag, " cfg_err"},   int'(cfg_err),   e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic p, input logic l, input int n,
                     input int sp, input int ix, input int b, input int d);
    vec_t v;
    v.start = s; v.stop = p; v.loop_en = l; v.n = n;
    v.speed = sp; v.idx = ix; v.busy = b; v.done = d;
    vq.push_back(v);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      start   = vq[i].start;
      stop    = vq[i].stop;
      loop_en = vq[i].loop_en;
      for (int k = 0; k < vq[i].n; k++) begin
        step();
        chk_outs($sformatf("%s[%0d.%0d]", tag, i, k),
                 vq[i].speed, vq[i].idx, vq[i].busy, vq[i].done, 0);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    vq.delete();
  endtask

  task automatic write_entry(input int a, input int s, input int d);
    cfg_addr  = AW'(a);
    cfg_speed = SPEED_W'(s);
    cfg_dur   = DUR_W'(d);
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic load_ramp();
    write_entry(0, 1, 1);
    write_entry(1, 2, 1);
    write_entry(2, 3, 1);
    write_entry(3, 4, 1);
  endtask

  initial begin
    #12;
    chk_outs("reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two-step pattern terminated by a zero-duration entry.
    write_entry(0, 5, 2);
    write_entry(1, 9, 3);
    write_entry(2, 0, 0);
    write_entry(3, 7, 7);
    add(1, 0, 0, 1,  5, 0, 1, 0);
    add(0, 0, 0, 7,  5, 0, 1, 0);
    add(0, 0, 0, 12, 9, 1, 1, 0);
    add(0, 0, 0, 1,  0, 0, 0, 1);
    add(0, 0, 0, 2,  0, 0, 0, 0);
    run_table("s2");

    // Full table looping without a gap, then loop_en dropped mid entry 2.
    load_ramp();
    add(1, 0, 1, 1, 1, 0, 1, 0);
    add(0, 0, 1, 3, 1, 0, 1, 0);
    add(0, 0, 1, 4, 2, 1, 1, 0);
    add(0, 0, 1, 4, 3, 2, 1, 0);
    add(0, 0, 1, 4, 4, 3, 1, 0);
    add(0, 0, 1, 4, 1, 0, 1, 0);
    add(0, 0, 1, 4, 2, 1, 1, 0);
    add(0, 0, 1, 2, 3, 2, 1, 0);
    add(0, 0, 0, 2, 3, 2, 1, 0);
    add(0, 0, 0, 4, 4, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 2, 0, 0, 0, 0);
    run_table("s3");

    // stop beats start in IDLE; stop in RUN aborts with no done.
    add(1, 1, 1, 2, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0, 1, 0);
    add(0, 0, 1, 3, 1, 0, 1, 0);
    add(0, 0, 1, 1, 2, 1, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 6, 0, 0, 0, 0);
    run_table("s4");

    // Asynchronous reset ten cycles into a run.
    loop_en = 1'b1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    repeat (9) step();
    chk("s1 pre-reset speed_out", int'(speed_out), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("s1 async", 0, 0, 0, 0, 0);
    step();
    chk_outs("s1 held", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk_outs("s1 after release", 0, 0, 0, 0, 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk_outs("s1 restart", 1, 0, 1, 0, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_outs("s1 stopped", 0, 0, 0, 0, 0);

    // Write attempt while running is rejected and flagged.
    loop_en = 1'b0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    chk("s5 run speed_out", int'(speed_out), 1);
    cfg_addr  = 2'd1;
    cfg_speed = 16'd15;
    cfg_dur   = 16'd9;
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
    chk("s5 cfg_err pulse", int'(cfg_err), 1);
    chk("s5 busy during err", int'(busy), 1);
    step();
    chk("s5 cfg_err cleared", int'(cfg_err), 0);
    step();
    chk("s5 entry0 last cycle", int'(speed_out), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("s5 old entry1 speed %0d", k), int'(speed_out), 2);
      chk($sformatf("s5 old entry1 idx %0d", k), int'(step_idx), 1);
    end
    step();
    chk("s5 entry2 speed", int'(speed_out), 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_outs("s5 stopped", 0, 0, 0, 0, 0);

    // Zero-duration first entry goes straight to FIN.
    write_entry(0, 6, 0);
    chk("s5 idle write no err", int'(cfg_err), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_outs("s5 empty fin", 0, 0, 0, 1, 0);
    step();
    chk_outs("s5 empty idle", 0, 0, 0, 0, 0);
    step();
    chk_outs("s5 empty idle2", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
Sequences a blink-rate datapath through a programmable pattern of up to DEPTH steps. Each step holds one blink speed for a fixed number of millisecond ticks. Outputs speed_out, which drives the speed input of the LED blink datapath. It sits between the top-level button/switch logic and the blinker, and owns the shared millisecond timebase.

Parameters:
DEPTH, 4, number of pattern table entries (power of 2, 2..16)
SPEED_W, 16, width of the speed field (blink half-period in ms ticks)
DUR_W, 16, width of the duration field (step length in ms ticks)
TICK_DIV, 100000, clk cycles per ms tick (100 MHz clock)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
cfg_we  in  1  write strobe for the pattern table
cfg_addr  in  $clog2(DEPTH)  table entry index
cfg_speed  in  SPEED_W  speed written to the entry
cfg_dur  in  DUR_W  duration written to the entry; 0 = end-of-pattern marker
start  in  1  level-sampled, rising-edge-free start request
stop  in  1  abort request
loop_en  in  1  1 = wrap to entry 0 after the last step
speed_out  out  SPEED_W  speed for the blink datapath; 0 = LED off
step_idx  out  $clog2(DEPTH)  index of the active entry
busy  out  1  high in RUN
done  out  1  one-cycle pulse when a non-looping pattern completes
cfg_err  out  1  one-cycle pulse when cfg_we is asserted while busy

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; speed_out=0, step_idx=0, busy=0, done=0, cfg_err=0, tick counter=0, remaining=0.
- Table contents are not reset; the bench must write every entry before use.
- Table writes:
  - cfg_we in IDLE writes {cfg_speed, cfg_dur} at cfg_addr on the clock edge.
  - cfg_we in RUN does not write; cfg_err pulses on the next cycle.
- FSM states: IDLE, RUN, FIN.
- IDLE to RUN: on start=1 and stop=0.
  - Next cycle: step_idx=0, speed_out=table[0].speed, remaining=table[0].dur, tick counter cleared, busy=1.
  - If table[0].dur==0, go to FIN instead; speed_out stays 0.
- RUN:
  - ms tick = internal tic, one cycle high every TICK_DIV clk cycles, counted from entry to RUN.
  - On tic: remaining decrements.
  - On tic with remaining==1: advance to the next entry.
  - Each step therefore lasts exactly dur*TICK_DIV cycles.
- Advance rule:
  - next = step_idx+1.
  - If next==DEPTH, or table[next].dur==0, the pattern ends.
  - Pattern end with loop_en=1: reload entry 0 in the same cycle, with no gap.
  - Pattern end with loop_en=0: go to FIN.
  - Otherwise load the next entry: speed_out, remaining and step_idx update on the same edge.
- loop_en is sampled only at the pattern-end decision.
- FIN: lasts one cycle; done=1, speed_out=0, busy=0, step_idx=0; then IDLE.
- stop=1 in any state: go to IDLE on the next edge, with speed_out=0, busy=0 and no done pulse. stop beats start when both are asserted.
- start asserted while in RUN is ignored; there is no restart.
- A start held high into IDLE after FIN restarts the pattern; this is intended.
- Arithmetic: remaining is DUR_W bits unsigned and never underflows, because it is loaded only with a nonzero dur. Tick counter width is $clog2(TICK_DIV).
- Every output is registered.

Decomposition:
- Package blink_pkg holds:
  - state_t enum {IDLE, RUN, FIN}
  - step_t struct {logic [SPEED_W-1:0] speed; logic [DUR_W-1:0] dur;}
  - localparam MS_DIV_DEFAULT = 100000
- One sub-module, ms_tick_gen (clk, rst_n, clr, tic): a modulo-TICK_DIV counter.
  - clr restarts the count.
  - tic pulses when the count wraps.
  - It replaces any per-blinker ms counter.
- The pattern table is a reg array inside blink_sequencer; no RAM macro is used.

Test Plan:
All scenarios use TICK_DIV=4 and DEPTH=4.
1. Reset mid-RUN: assert rst_n=0 at cycle 10 of a run -> outputs are 0 and state is IDLE immediately, without waiting for a clock edge; after release, start is required to run again.
2. Table {(5,2),(9,3),(0,0),x}, loop_en=0, start for 1 cycle:
   - speed_out=5 for 8 cycles, then 9 for 12 cycles.
   - Then done pulses for 1 cycle, speed_out=0, busy=0.
   - step_idx shows 0 then 1.
3. Full table {(1,1),(2,1),(3,1),(4,1)}, loop_en=1:
   - speed_out cycles 1,2,3,4,1,2, each for 4 cycles, with no zero gap at the wrap.
   - done never pulses.
   - Deasserting loop_en mid-entry 2 gives FIN after entry 3.
4. stop and start asserted in the same IDLE cycle -> stays IDLE, speed_out=0. stop asserted in RUN during entry 1 -> speed_out=0 on the next cycle, no done pulse.
5. cfg_we during RUN writing addr 1 -> cfg_err pulses for 1 cycle; entry 1 still plays its old value. Entry 0 dur=0 then start -> FIN on the next cycle, done=1, busy never rises.
